// File: rtl/rv32im_dmem_arb.sv
// Two-master round-robin arbiter for the single data-memory port (LSU = master 0, debug/DMA = master 1).
// Optional BUSY watchdog enabled by defining DMEM_ARB_TIMEOUT_EN.
module rv32im_dmem_arb #(
  parameter int API_ADDR_WIDTH = 32,
  parameter int API_DATA_WIDTH = 32,
  parameter int ARB_TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  m2arb_req_i,
  input  logic [1:0]                  m2arb_cmd_i,
  input  logic [5:0]                  m2arb_width_i,
  input  logic [2*API_ADDR_WIDTH-1:0] m2arb_addr_i,
  input  logic [2*API_DATA_WIDTH-1:0] m2arb_wdata_i,
  output logic [1:0]                  arb2m_req_ack_o,
  output logic [API_DATA_WIDTH-1:0]   arb2m_rdata_o,
  output logic [3:0]                  arb2m_resp_o,
  output logic                        arb2dmem_req_o,
  output logic                        arb2dmem_cmd_o,
  output logic [2:0]                  arb2dmem_width_o,
  output logic [API_ADDR_WIDTH-1:0]   arb2dmem_addr_o,
  output logic [API_DATA_WIDTH-1:0]   arb2dmem_wdata_o,
  input  logic                        dmem2arb_req_ack_i,
  input  logic [API_DATA_WIDTH-1:0]   dmem2arb_rdata_i,
  input  logic [1:0]                  dmem2arb_resp_i,
  output logic                        arb_busy_o,
  output logic                        arb_owner_o
);

  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_RDY_OK = 2'b01;
  localparam logic [1:0] RESP_RDY_ER = 2'b10;

  if (ARB_TIMEOUT < 1 || ARB_TIMEOUT > 255) begin : g_bad_timeout
    $error("ARB_TIMEOUT must be within 1..255");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;
  logic   sel, any_req, resp_done;
  logic [1:0] resp_v;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO = 8'(ARB_TIMEOUT);
  logic [7:0] cnt_q, cnt_d;
`endif

  assign any_req = |m2arb_req_i;
  // Tie goes to whoever did not win last; otherwise the lone requester.
  assign sel     = (m2arb_req_i[0] & m2arb_req_i[1]) ? ~last_grant_q : m2arb_req_i[1];

  assign arb2dmem_cmd_o   = m2arb_cmd_i[sel];
  assign arb2dmem_width_o = sel ? m2arb_width_i[5:3] : m2arb_width_i[2:0];
  assign arb2dmem_addr_o  = sel ? m2arb_addr_i[2*API_ADDR_WIDTH-1:API_ADDR_WIDTH]
                                : m2arb_addr_i[API_ADDR_WIDTH-1:0];
  assign arb2dmem_wdata_o = sel ? m2arb_wdata_i[2*API_DATA_WIDTH-1:API_DATA_WIDTH]
                                : m2arb_wdata_i[API_DATA_WIDTH-1:0];
  assign arb2m_rdata_o    = dmem2arb_rdata_i;
  assign arb_busy_o       = (state_q == BUSY);
  assign arb_owner_o      = owner_q;

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    arb2dmem_req_o  = 1'b0;
    arb2m_req_ack_o = 2'b00;
    arb2m_resp_o    = {RESP_NOTRDY, RESP_NOTRDY};
    resp_v          = dmem2arb_resp_i;
    resp_done       = (dmem2arb_resp_i == RESP_RDY_OK) || (dmem2arb_resp_i == RESP_RDY_ER);
`ifdef DMEM_ARB_TIMEOUT_EN
    cnt_d           = 8'd0;
    if (state_q == BUSY && !resp_done && cnt_q == TMO) begin
      resp_v    = RESP_RDY_ER;
      resp_done = 1'b1;
    end
`endif
    case (state_q)
      IDLE: begin
        arb2dmem_req_o       = any_req;
        arb2m_req_ack_o[sel] = dmem2arb_req_ack_i & any_req;
        if (dmem2arb_req_ack_i && any_req) begin
          owner_d      = sel;
          last_grant_d = sel;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (owner_q) arb2m_resp_o[3:2] = resp_v;
        else         arb2m_resp_o[1:0] = resp_v;
`ifdef DMEM_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 8'd1;
`endif
        if (resp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef DMEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 8'd0;
    else      cnt_q <= cnt_d;
  end
`endif

endmodule

// File: tb/tb_rv32im_dmem_arb.sv
// Directed self-checking bench for rv32im_dmem_arb; timeout case runs when DMEM_ARB_TIMEOUT_EN is defined.
module tb_rv32im_dmem_arb;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_2200;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, cmd;
  logic [5:0]  width;
  logic [63:0] addr, wdata;
  logic [1:0]  ack_o;
  logic [31:0] rdata_o;
  logic [3:0]  resp_o;
  logic        dreq_o, dcmd_o;
  logic [2:0]  dwidth_o;
  logic [31:0] daddr_o, dwdata_o;
  logic        dack;
  logic [31:0] drdata;
  logic [1:0]  dresp;
  logic        busy_o, owner_o;

  int n_checks = 0;
  int n_errors = 0;

  rv32im_dmem_arb #(.API_ADDR_WIDTH(32), .API_DATA_WIDTH(32), .ARB_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m2arb_req_i(req), .m2arb_cmd_i(cmd), .m2arb_width_i(width),
    .m2arb_addr_i(addr), .m2arb_wdata_i(wdata),
    .arb2m_req_ack_o(ack_o), .arb2m_rdata_o(rdata_o), .arb2m_resp_o(resp_o),
    .arb2dmem_req_o(dreq_o), .arb2dmem_cmd_o(dcmd_o), .arb2dmem_width_o(dwidth_o),
    .arb2dmem_addr_o(daddr_o), .arb2dmem_wdata_o(dwdata_o),
    .dmem2arb_req_ack_i(dack), .dmem2arb_rdata_i(drdata), .dmem2arb_resp_i(dresp),
    .arb_busy_o(busy_o), .arb_owner_o(owner_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // inputs are driven just after posedge; outputs sampled at the following negedge
  task automatic drive(input logic [1:0] r, input logic a, input logic [1:0] rs, input logic [31:0] rd);
    req = r; dack = a; dresp = rs; drdata = rd;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req = 2'b00; dack = 1'b0; dresp = 2'b00;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    cmd = 2'b10; width = {3'd2, 3'd1};
    addr = {A1, A0}; wdata = {32'h1111_1111, 32'h0000_0000};
    drdata = 32'h0;
    do_reset();

    // reset state
    drive(2'b00, 1'b0, 2'b00, 32'h0);
    check("rst_busy",  {31'b0, busy_o},  32'd0);
    check("rst_owner", {31'b0, owner_o}, 32'd0);
    check("rst_dreq",  {31'b0, dreq_o},  32'd0);
    check("rst_ack",   {30'b0, ack_o},   32'd0);
    check("rst_resp",  {28'b0, resp_o},  32'd0);
    next_cycle();

    // master 0 read, OK response two cycles after ack
    drive(2'b01, 1'b1, 2'b00, 32'h0);
    check("t1_ack",   {30'b0, ack_o},    32'd1);
    check("t1_addr",  daddr_o,           A0);
    check("t1_cmd",   {31'b0, dcmd_o},   32'd0);
    check("t1_width", {29'b0, dwidth_o}, 32'd1);
    next_cycle();
    drive(2'b00, 1'b0, 2'b00, 32'h0);
    check("t1_busy",  {31'b0, busy_o},  32'd1);
    check("t1_wait",  {28'b0, resp_o},  32'd0);
    next_cycle();
    drive(2'b00, 1'b0, 2'b01, 32'hDEAD_BEEF);
    check("t1_resp",  {28'b0, resp_o},  32'b0001);
    check("t1_rdata", rdata_o,          32'hDEAD_BEEF);
    check("t1_owner", {31'b0, owner_o}, 32'd0);
    next_cycle();
    drive(2'b00, 1'b0, 2'b00, 32'h0);
    check("t1_idle",  {31'b0, busy_o},  32'd0);
    next_cycle();

    // both masters continuously; alternating 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 2'b00, 32'h0);
      check("t2_ack",  {30'b0, ack_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check("t2_addr", daddr_o,        (i % 2 == 0) ? A0 : A1);
      next_cycle();
      drive(2'b11, 1'b0, 2'b01, 32'h0);
      check("t2_resp", {28'b0, resp_o}, (i % 2 == 0) ? 32'b0001 : 32'b0100);
      check("t2_noack", {30'b0, ack_o}, 32'd0);
      next_cycle();
    end

    // master 1 write, error response
    do_reset();
    drive(2'b10, 1'b1, 2'b00, 32'h0);
    check("t3_ack",   {30'b0, ack_o},    32'd2);
    check("t3_cmd",   {31'b0, dcmd_o},   32'd1);
    check("t3_wdata", dwdata_o,          32'h1111_1111);
    check("t3_width", {29'b0, dwidth_o}, 32'd2);
    next_cycle();
    drive(2'b00, 1'b0, 2'b10, 32'h0);
    check("t3_resp",  {28'b0, resp_o},  32'b1000);
    check("t3_owner", {31'b0, owner_o}, 32'd1);
    next_cycle();
    drive(2'b00, 1'b0, 2'b00, 32'h0);
    check("t3_idle",  {31'b0, busy_o},  32'd0);
    next_cycle();

    // master 0 requests without ack then drops; pointer must not move
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, 1'b0, 2'b00, 32'h0);
      check("t4_dreq",  {31'b0, dreq_o}, 32'd1);
      check("t4_noack", {30'b0, ack_o},  32'd0);
      next_cycle();
    end
    drive(2'b11, 1'b0, 2'b00, 32'h0);
    check("t4_tie_sel", daddr_o, A0);
    next_cycle();
    drive(2'b10, 1'b1, 2'b00, 32'h0);
    check("t4_ack1", {30'b0, ack_o}, 32'd2);
    next_cycle();
    drive(2'b00, 1'b0, 2'b00, 32'h0);
    check("t4_owner", {31'b0, owner_o}, 32'd1);
    check("t4_busy",  {31'b0, busy_o},  32'd1);
    next_cycle();
    drive(2'b00, 1'b0, 2'b01, 32'h0);
    check("t4_resp", {28'b0, resp_o}, 32'b0100);
    next_cycle();

    // reset while BUSY; late response must be dropped
    do_reset();
    drive(2'b01, 1'b1, 2'b00, 32'h0);
    next_cycle();
    drive(2'b00, 1'b0, 2'b00, 32'h0);
    check("t5_busy_pre", {31'b0, busy_o}, 32'd1);
    rst = 1'b0;
    #1;
    check("t5_busy_rst", {31'b0, busy_o}, 32'd0);
    check("t5_resp_rst", {28'b0, resp_o}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    drive(2'b00, 1'b0, 2'b01, 32'hCAFE_F00D);
    check("t5_late_resp", {28'b0, resp_o}, 32'd0);
    check("t5_late_busy", {31'b0, busy_o}, 32'd0);
    next_cycle();
    drive(2'b11, 1'b1, 2'b00, 32'h0);
    check("t5_tie_ack", {30'b0, ack_o}, 32'd1);
    next_cycle();
    drive(2'b00, 1'b0, 2'b01, 32'h0);
    next_cycle();

`ifdef DMEM_ARB_TIMEOUT_EN
    // watchdog: DMEM never answers
    do_reset();
    drive(2'b01, 1'b1, 2'b00, 32'h0);
    next_cycle();
    for (int i = 0; i < TMO; i++) begin
      drive(2'b00, 1'b0, 2'b00, 32'h0);
      check("t6_wait", {28'b0, resp_o}, 32'd0);
      next_cycle();
    end
    drive(2'b00, 1'b0, 2'b00, 32'h0);
    check("t6_tmo_resp", {28'b0, resp_o}, 32'b0010);
    next_cycle();
    drive(2'b00, 1'b0, 2'b00, 32'h0);
    check("t6_idle", {31'b0, busy_o}, 32'd0);
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
